// File: rtl/imem_responder.sv
// imem_responder: preloadable instruction memory with fixed-latency, in-order, FIFO-buffered responses.
// Define IMEM_ERR_CHECK_EN to flag misaligned or out-of-range addresses.
module imem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2,
   parameter int RESP_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        flush,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_data,
   output logic [31:0] resp_addr,
   output logic        resp_err,
   input  logic        load_en,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int PW = $clog2(RESP_DEPTH);

   logic [31:0]   mem [DEPTH_WORDS];
   logic [AW-1:0] rd_idx;
   logic [AW-1:0] ld_idx;
   logic          acc;
   logic          rd_err;
   logic          ld_ok;
   logic [31:0]   rd_word;

   logic          push_v;
   logic [31:0]   push_data;
   logic [31:0]   push_addr;
   logic          push_err;
   logic [7:0]    in_flight;
   logic [15:0]   occ;

   logic [31:0]   f_data [RESP_DEPTH];
   logic [31:0]   f_addr [RESP_DEPTH];
   logic [RESP_DEPTH-1:0] f_err;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          pop;

   assign rd_idx = req_addr[AW+1:2];
   assign ld_idx = load_addr[AW+1:2];

`ifdef IMEM_ERR_CHECK_EN
   localparam logic [32:0] LIMIT = 33'(4 * DEPTH_WORDS);
   assign rd_err  = (req_addr[1:0] != 2'b00) ||
                    ({1'b0, req_addr} >= LIMIT);
   assign ld_ok   = (load_addr[1:0] == 2'b00) &&
                    ({1'b0, load_addr} < LIMIT);
   assign rd_word = rd_err ? 32'h0 : mem[rd_idx];
`else
   logic unused_ld;
   assign rd_err    = 1'b0;
   assign ld_ok     = 1'b1;
   assign rd_word   = mem[rd_idx];
   assign unused_ld = ^{load_addr[31:AW+2], load_addr[1:0]};
`endif

   // Occupancy counts every in-flight stage so an accept always has a FIFO slot.
   assign occ       = 16'(in_flight) + 16'(count);
   assign req_ready = rst && !flush && (occ < 16'(RESP_DEPTH));
   assign acc       = req_valid && req_ready;

   // Array write lands at the edge, so a same-cycle read sees the old word.
   always_ff @(posedge clk) begin
      if (load_en && ld_ok) mem[ld_idx] <= load_data;
   end

   generate
      if (LATENCY == 1) begin : g_direct
         assign push_v    = acc;
         assign push_data = rd_word;
         assign push_addr = req_addr;
         assign push_err  = rd_err;
         assign in_flight = '0;
      end else begin : g_pipe
         logic [LATENCY-2:0] v;
         logic [LATENCY-2:0] e;
         logic [31:0]        d [LATENCY-1];
         logic [31:0]        a [LATENCY-1];

         always_ff @(posedge clk) begin
            if (!rst || flush) begin
               v <= '0;
            end else begin
               v[0] <= acc;
               for (int k = 1; k < LATENCY - 1; k++) v[k] <= v[k-1];
            end
         end

         always_ff @(posedge clk) begin
            d[0] <= rd_word;
            a[0] <= req_addr;
            e[0] <= rd_err;
            for (int k = 1; k < LATENCY - 1; k++) begin
               d[k] <= d[k-1];
               a[k] <= a[k-1];
               e[k] <= e[k-1];
            end
         end

         assign push_v    = v[LATENCY-2];
         assign push_data = d[LATENCY-2];
         assign push_addr = a[LATENCY-2];
         assign push_err  = e[LATENCY-2];
         assign in_flight = 8'($countones(v));
      end
   endgenerate

   assign resp_valid = rst && (count != '0);
   assign pop        = resp_valid && resp_ready;
   assign resp_data  = resp_valid ? f_data[rd_ptr] : 32'h0;
   assign resp_addr  = resp_valid ? f_addr[rd_ptr] : 32'h0;
   assign resp_err   = resp_valid && f_err[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_v) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push_v && !pop) count <= count + 1'b1;
         else if (!push_v && pop) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_v) begin
         f_data[wr_ptr] <= push_data;
         f_addr[wr_ptr] <= push_addr;
         f_err[wr_ptr]  <= push_err;
      end
   end
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed checks of latency, ordering, backpressure, flush, reset and preload.
// Honours IMEM_ERR_CHECK_EN for the address-check expectations.
module tb_imem_responder;
   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        flush;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic [31:0] resp_addr;
   logic        resp_err;
   logic        load_en;
   logic [31:0] load_addr;
   logic [31:0] load_data;
   logic [64:0] got;
   logic [64:0] exp;

   int tests = 0;
   int fails = 0;
   logic [31:0] words [4];

   always #5 clk = ~clk;

   imem_responder #(
      .DEPTH_WORDS(1024),
      .LATENCY(2),
      .RESP_DEPTH(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_addr(req_addr),
      .flush(flush),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_data(resp_data),
      .resp_addr(resp_addr),
      .resp_err(resp_err),
      .load_en(load_en),
      .load_addr(load_addr),
      .load_data(load_data)
   );

   assign got = {resp_valid, resp_err, resp_addr, resp_data};

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic [31:0] a, input logic [31:0] d);
      load_en = 1'b1;
      load_addr = a;
      load_data = d;
      nxt();
      load_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      req_valid = 1'b1;
      req_addr = 32'h0;
      resp_ready = 1'b1;
      nxt();
      nxt();
      #1;
      tests++;
      if (req_ready !== 1'b0) begin
         fails++;
         $display("FAIL reset_req_ready: got %b want 0", req_ready);
      end
      tests++;
      if (got !== 65'h0) begin
         fails++;
         $display("FAIL reset_resp: got %h want 0", got);
      end
      rst = 1'b1;
      req_valid = 1'b0;
      #1;
      tests++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         fails++;
         $display("FAIL post_reset: got ready=%b valid=%b want 1/0",
                  req_ready, resp_valid);
      end
   endtask

   task automatic test_back_to_back();
      resp_ready = 1'b1;
      req_valid = 1'b1;
      req_addr = 32'h0;
      #1;
      tests++;
      if (req_ready !== 1'b1) begin
         fails++;
         $display("FAIL b2b_ready: got %b want 1", req_ready);
      end
      nxt();
      req_addr = 32'h4;
      #1;
      tests++;
      if (resp_valid !== 1'b0) begin
         fails++;
         $display("FAIL b2b_early: got valid %b want 0", resp_valid);
      end
      nxt();
      req_valid = 1'b0;
      #1;
      exp = {1'b1, 1'b0, 32'h0, 32'h0000_0013};
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL b2b_resp0: got %h want %h", got, exp);
      end
      nxt();
      #1;
      exp = {1'b1, 1'b0, 32'h4, 32'h0010_0093};
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL b2b_resp1: got %h want %h", got, exp);
      end
      nxt();
      #1;
      tests++;
      if (resp_valid !== 1'b0) begin
         fails++;
         $display("FAIL b2b_drain: got valid %b want 0", resp_valid);
      end
   endtask

   task automatic test_throughput();
      resp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         req_valid = (i < 4);
         req_addr = 32'(4 * i);
         #1;
         if (i < 4) begin
            tests++;
            if (req_ready !== 1'b1) begin
               fails++;
               $display("FAIL tput_ready%0d: got %b want 1", i, req_ready);
            end
         end
         if (i >= 2) begin
            exp = {1'b1, 1'b0, 32'(4 * (i - 2)), words[i-2]};
            tests++;
            if (got !== exp) begin
               fails++;
               $display("FAIL tput_resp%0d: got %h want %h", i - 2, got, exp);
            end
         end
         nxt();
      end
      #1;
      tests++;
      if (resp_valid !== 1'b0) begin
         fails++;
         $display("FAIL tput_drain: got valid %b want 0", resp_valid);
      end
   endtask

   task automatic test_backpressure();
      int n;
      logic [31:0] acc_addr [6];
      n = 0;
      resp_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         req_valid = 1'b1;
         req_addr = 32'(4 * i);
         #1;
         if (req_ready === 1'b1) begin
            acc_addr[n] = req_addr;
            n++;
         end
         nxt();
      end
      req_valid = 1'b0;
      tests++;
      if (n != 4) begin
         fails++;
         $display("FAIL bp_accepted: got %0d want 4", n);
      end
      for (int i = 0; i < 4 && i < n; i++) begin
         tests++;
         if (acc_addr[i] !== 32'(4 * i)) begin
            fails++;
            $display("FAIL bp_acc_addr%0d: got %h want %h",
                     i, acc_addr[i], 32'(4 * i));
         end
      end
      exp = {1'b1, 1'b0, 32'h0, words[0]};
      for (int h = 0; h < 2; h++) begin
         #1;
         tests++;
         if (req_ready !== 1'b0 || got !== exp) begin
            fails++;
            $display("FAIL bp_hold%0d: got ready=%b resp=%h want 0/%h",
                     h, req_ready, got, exp);
         end
         nxt();
      end
      resp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         exp = {1'b1, 1'b0, 32'(4 * k), words[k]};
         tests++;
         if (got !== exp) begin
            fails++;
            $display("FAIL bp_resp%0d: got %h want %h", k, got, exp);
         end
         nxt();
      end
      #1;
      tests++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         fails++;
         $display("FAIL bp_after: got valid=%b ready=%b want 0/1",
                  resp_valid, req_ready);
      end
   endtask

   task automatic test_flush();
      resp_ready = 1'b0;
      req_valid = 1'b1;
      req_addr = 32'h0;
      nxt();
      req_addr = 32'h4;
      nxt();
      req_addr = 32'hC;
      nxt();
      flush = 1'b1;
      req_addr = 32'h10;
      #1;
      tests++;
      if (req_ready !== 1'b0) begin
         fails++;
         $display("FAIL flush_ready: got %b want 0", req_ready);
      end
      nxt();
      flush = 1'b0;
      resp_ready = 1'b1;
      req_addr = 32'h8;
      #1;
      tests++;
      if (resp_valid !== 1'b0) begin
         fails++;
         $display("FAIL flush_empty: got valid %b want 0", resp_valid);
      end
      nxt();
      req_valid = 1'b0;
      #1;
      tests++;
      if (resp_valid !== 1'b0) begin
         fails++;
         $display("FAIL flush_stage: got valid %b want 0", resp_valid);
      end
      nxt();
      #1;
      exp = {1'b1, 1'b0, 32'h8, words[2]};
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL flush_resp: got %h want %h", got, exp);
      end
      nxt();
      #1;
      tests++;
      if (resp_valid !== 1'b0) begin
         fails++;
         $display("FAIL flush_only: got valid %b want 0", resp_valid);
      end
   endtask

   task automatic test_err();
      logic        e;
      logic [31:0] d;
`ifdef IMEM_ERR_CHECK_EN
      e = 1'b1;
      d = 32'h0;
`else
      e = 1'b0;
      d = words[0];
`endif
      resp_ready = 1'b1;
      req_valid = 1'b1;
      req_addr = 32'h2;
      nxt();
      req_addr = 32'h1000;
      nxt();
      req_valid = 1'b0;
      #1;
      exp = {1'b1, e, 32'h2, d};
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL err_misalign: got %h want %h", got, exp);
      end
      nxt();
      #1;
      exp = {1'b1, e, 32'h1000, d};
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL err_range: got %h want %h", got, exp);
      end
      nxt();
   endtask

   task automatic test_reset_midflight();
      resp_ready = 1'b1;
      req_valid = 1'b1;
      req_addr = 32'h4;
      nxt();
      rst = 1'b0;
      req_valid = 1'b0;
      #1;
      tests++;
      if (req_ready !== 1'b0 || got !== 65'h0) begin
         fails++;
         $display("FAIL rstmid_during: got ready=%b resp=%h want 0/0",
                  req_ready, got);
      end
      nxt();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         tests++;
         if (resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_leak%0d: got valid %b want 0", i, resp_valid);
         end
         nxt();
      end
      req_valid = 1'b1;
      req_addr = 32'h4;
      nxt();
      req_valid = 1'b0;
      nxt();
      #1;
      exp = {1'b1, 1'b0, 32'h4, words[1]};
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL rstmid_array: got %h want %h", got, exp);
      end
      nxt();
   endtask

   task automatic test_load_collision();
      resp_ready = 1'b1;
      load_en = 1'b1;
      load_addr = 32'h8;
      load_data = 32'hDEAD_BEEF;
      req_valid = 1'b1;
      req_addr = 32'h8;
      nxt();
      load_en = 1'b0;
      nxt();
      req_valid = 1'b0;
      #1;
      exp = {1'b1, 1'b0, 32'h8, words[2]};
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL load_old: got %h want %h", got, exp);
      end
      nxt();
      #1;
      exp = {1'b1, 1'b0, 32'h8, 32'hDEAD_BEEF};
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL load_new: got %h want %h", got, exp);
      end
      nxt();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      words[0] = 32'h0000_0013;
      words[1] = 32'h0010_0093;
      words[2] = 32'h1111_1111;
      words[3] = 32'h2222_2222;
      rst = 1'b0;
      req_valid = 1'b0;
      req_addr = 32'h0;
      flush = 1'b0;
      resp_ready = 1'b0;
      load_en = 1'b0;
      load_addr = 32'h0;
      load_data = 32'h0;
      test_reset();
      for (int i = 0; i < 4; i++) load_word(32'(4 * i), words[i]);
      test_back_to_back();
      test_throughput();
      test_backpressure();
      test_flush();
      test_err();
      test_reset_midflight();
      test_load_collision();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
